// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/redirect controller: resolves per-stage stall requests,
// issues (or holds pending) branch/trap redirects, and watches for stuck stalls.
module pipe_hazard_ctrl #(
    parameter int STAGES       = 5,
    parameter int ADDR_W       = 32,
    parameter int BRANCH_STAGE = 2,
    parameter int TRAP_STAGE   = 3,
    parameter int TIMEOUT      = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stall_req_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    input  logic              trap_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              timeout_clr_i,
    output logic [STAGES-1:0] stall_o,
    output logic [STAGES-1:0] flush_o,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic              redirect_trap_o,
    output logic              stall_timeout_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [STAGES-1:0] BR_MASK = STAGES'((1 << BRANCH_STAGE) - 1);
    localparam logic [STAGES-1:0] TR_MASK = STAGES'((1 << (TRAP_STAGE + 1)) - 1);

    typedef enum logic [1:0] {RUN, PEND_BR, PEND_TRAP} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] br_addr_q, br_addr_d;
    logic [ADDR_W-1:0] tr_addr_q, tr_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flag_q, flag_d;

    logic [STAGES-1:0] stall_base, kill, stall_fin, flush_fin;
    logic              blocked_br, blocked_tr, issue_br, issue_tr;
    logic [ADDR_W-1:0] addr_sel;

    // stall_base[j] = some stage at or above j requests a stall, i.e. j <= h
    always_comb begin
        stall_base = '0;
        stall_base[STAGES-1] = stall_req_i[STAGES-1];
        for (int j = STAGES - 2; j >= 0; j--)
            stall_base[j] = stall_base[j+1] | stall_req_i[j];
    end

    assign blocked_br = stall_base[BRANCH_STAGE];
    assign blocked_tr = stall_base[TRAP_STAGE];

    always_comb begin
        state_d   = state_q;
        br_addr_d = br_addr_q;
        tr_addr_d = tr_addr_q;
        issue_br  = 1'b0;
        issue_tr  = 1'b0;
        addr_sel  = '0;
        case (state_q)
            RUN: begin
                if (trap_i) begin
                    if (blocked_tr) begin
                        state_d   = PEND_TRAP;
                        tr_addr_d = trap_addr_i;
                    end else begin
                        issue_tr = 1'b1;
                        addr_sel = trap_addr_i;
                    end
                end else if (branch_flag_i) begin
                    if (blocked_br) begin
                        state_d   = PEND_BR;
                        br_addr_d = branch_addr_i;
                    end else begin
                        issue_br = 1'b1;
                        addr_sel = branch_addr_i;
                    end
                end
            end
            PEND_BR: begin
                // a new trap always supersedes the held branch
                if (trap_i && blocked_tr) begin
                    state_d   = PEND_TRAP;
                    tr_addr_d = trap_addr_i;
                end else if (trap_i) begin
                    issue_tr = 1'b1;
                    addr_sel = trap_addr_i;
                    state_d  = RUN;
                end else if (!blocked_br) begin
                    issue_br = 1'b1;
                    addr_sel = br_addr_q;
                    state_d  = RUN;
                end
            end
            PEND_TRAP: begin
                if (!blocked_tr) begin
                    issue_tr = 1'b1;
                    addr_sel = tr_addr_q;
                    state_d  = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // A redirect overrides the younger stalls; the bubble follows the surviving stall edge.
    assign kill      = issue_tr ? TR_MASK : (issue_br ? BR_MASK : '0);
    assign stall_fin = stall_base & ~kill;
    assign flush_fin = kill | {stall_fin[STAGES-2:0] & ~stall_fin[STAGES-1:1], 1'b0};

    always_comb begin
        cnt_d = cnt_q;
        if (timeout_clr_i || stall_req_i == '0)
            cnt_d = '0;
        else if (cnt_q != CNT_W'(TIMEOUT))
            cnt_d = cnt_q + 1'b1;
        flag_d = timeout_clr_i ? 1'b0 : (flag_q | (cnt_d == CNT_W'(TIMEOUT)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            br_addr_q <= '0;
            tr_addr_q <= '0;
            cnt_q     <= '0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            br_addr_q <= br_addr_d;
            tr_addr_q <= tr_addr_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
        end
    end

    assign stall_o         = rst ? '0 : stall_fin;
    assign flush_o         = rst ? '0 : flush_fin;
    assign redirect_o      = ~rst & (issue_br | issue_tr);
    assign redirect_addr_o = rst ? '0 : addr_sel;
    assign redirect_trap_o = ~rst & issue_tr;
    assign stall_timeout_o = ~rst & flag_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (5 stages, watchdog TIMEOUT = 4).
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  stall_req_i = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        trap_i = 1'b0;
    logic [31:0] trap_addr_i = '0;
    logic        timeout_clr_i = 1'b0;
    logic [4:0]  stall_o, flush_o;
    logic        redirect_o, redirect_trap_o, stall_timeout_o;
    logic [31:0] redirect_addr_o;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.STAGES(5), .ADDR_W(32), .BRANCH_STAGE(2), .TRAP_STAGE(3), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .stall_req_i(stall_req_i),
        .branch_flag_i(branch_flag_i), .branch_addr_i(branch_addr_i),
        .trap_i(trap_i), .trap_addr_i(trap_addr_i), .timeout_clr_i(timeout_clr_i),
        .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
        .redirect_addr_o(redirect_addr_o), .redirect_trap_o(redirect_trap_o),
        .stall_timeout_o(stall_timeout_o)
    );

    typedef struct {
        int          id;
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        red;
        logic [31:0] addr;
        logic        trap;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int step_id = 0;

    task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got %h expected %h", id, name, act, exp);
        end
    endtask

    // monitor: the DUT presents a full output set every cycle; check mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.id, "stall_o", 32'(stall_o), 32'(e.stall));
                chk(e.id, "flush_o", 32'(flush_o), 32'(e.flush));
                chk(e.id, "redirect_o", 32'(redirect_o), 32'(e.red));
                chk(e.id, "redirect_addr_o", redirect_addr_o, e.addr);
                chk(e.id, "redirect_trap_o", 32'(redirect_trap_o), 32'(e.trap));
                chk(e.id, "stall_timeout_o", 32'(stall_timeout_o), 32'(e.to));
            end
        end
    end

    task automatic step(input logic r, input logic [4:0] req,
                        input logic br, input logic [31:0] ba,
                        input logic tr, input logic [31:0] ta, input logic clr,
                        input logic [4:0] es, input logic [4:0] ef, input logic er,
                        input logic [31:0] ea, input logic et, input logic eto);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stall_req_i = req;
        branch_flag_i = br; branch_addr_i = ba;
        trap_i = tr; trap_addr_i = ta; timeout_clr_i = clr;
        e.id = step_id; e.stall = es; e.flush = ef; e.red = er;
        e.addr = ea; e.trap = et; e.to = eto;
        sb.push_back(e);
        step_id++;
    endtask

    initial begin
        //   rst req      br  baddr         tr  taddr         clr  stall    flush    red addr          trp to
        step(1, 5'b00100, 0, 32'h0,        0, 32'h0,        0,   5'b00000, 5'b00000, 0, 32'h0,        0, 0); // 0 in reset
        step(0, 5'b00100, 0, 32'h0,        0, 32'h0,        0,   5'b00111, 5'b01000, 0, 32'h0,        0, 0); // 1 plain stall
        step(0, 5'b00010, 1, 32'h80000040, 0, 32'h0,        0,   5'b00000, 5'b00011, 1, 32'h80000040, 0, 0); // 2 unblocked branch
        step(0, 5'b01000, 1, 32'h100,      0, 32'h0,        0,   5'b01111, 5'b10000, 0, 32'h0,        0, 0); // 3 branch held
        step(0, 5'b01000, 1, 32'h200,      0, 32'h0,        0,   5'b01111, 5'b10000, 0, 32'h0,        0, 0); // 4 second branch ignored
        step(0, 5'b01000, 0, 32'h0,        0, 32'h0,        0,   5'b01111, 5'b10000, 0, 32'h0,        0, 1); // 5 watchdog fired (4 stall cycles)
        step(0, 5'b00000, 0, 32'h0,        0, 32'h0,        0,   5'b00000, 5'b00011, 1, 32'h100,      0, 1); // 6 pending branch released
        step(0, 5'b00000, 0, 32'h0,        0, 32'h0,        1,   5'b00000, 5'b00000, 0, 32'h0,        0, 1); // 7 clear pulse
        step(0, 5'b00000, 0, 32'h0,        0, 32'h0,        0,   5'b00000, 5'b00000, 0, 32'h0,        0, 0); // 8 flag cleared
        step(0, 5'b00000, 1, 32'h300,      1, 32'h80000004, 0,   5'b00000, 5'b01111, 1, 32'h80000004, 1, 0); // 9 trap beats branch
        step(0, 5'b00000, 0, 32'h0,        0, 32'h0,        0,   5'b00000, 5'b00000, 0, 32'h0,        0, 0); // 10 branch discarded
        step(0, 5'b00001, 0, 32'h0,        0, 32'h0,        0,   5'b00001, 5'b00010, 0, 32'h0,        0, 0); // 11 watchdog run
        step(0, 5'b00001, 0, 32'h0,        0, 32'h0,        0,   5'b00001, 5'b00010, 0, 32'h0,        0, 0); // 12
        step(0, 5'b00001, 0, 32'h0,        0, 32'h0,        0,   5'b00001, 5'b00010, 0, 32'h0,        0, 0); // 13
        step(0, 5'b00001, 0, 32'h0,        0, 32'h0,        0,   5'b00001, 5'b00010, 0, 32'h0,        0, 0); // 14 4th stall cycle
        step(0, 5'b00000, 0, 32'h0,        0, 32'h0,        0,   5'b00000, 5'b00000, 0, 32'h0,        0, 1); // 15 sticky after stall ends
        step(0, 5'b00000, 0, 32'h0,        0, 32'h0,        0,   5'b00000, 5'b00000, 0, 32'h0,        0, 1); // 16
        step(0, 5'b00000, 0, 32'h0,        0, 32'h0,        1,   5'b00000, 5'b00000, 0, 32'h0,        0, 1); // 17 clear
        step(0, 5'b00000, 0, 32'h0,        0, 32'h0,        0,   5'b00000, 5'b00000, 0, 32'h0,        0, 0); // 18
        step(0, 5'b10000, 1, 32'h50,       1, 32'h40,       0,   5'b11111, 5'b00000, 0, 32'h0,        0, 0); // 19 trap held, branch dropped
        step(0, 5'b10000, 0, 32'h0,        1, 32'h60,       0,   5'b11111, 5'b00000, 0, 32'h0,        0, 0); // 20 second trap ignored
        step(0, 5'b00100, 0, 32'h0,        0, 32'h0,        0,   5'b00000, 5'b01111, 1, 32'h40,       1, 0); // 21 pending trap released
        step(0, 5'b00000, 0, 32'h0,        0, 32'h0,        0,   5'b00000, 5'b00000, 0, 32'h0,        0, 0); // 22
        step(0, 5'b00100, 1, 32'h70,       0, 32'h0,        0,   5'b00111, 5'b01000, 0, 32'h0,        0, 0); // 23 branch blocked at EX
        step(0, 5'b00000, 0, 32'h0,        1, 32'h90,       0,   5'b00000, 5'b01111, 1, 32'h90,       1, 0); // 24 trap wins release
        step(0, 5'b00000, 0, 32'h0,        0, 32'h0,        0,   5'b00000, 5'b00000, 0, 32'h0,        0, 0); // 25 branch gone
        step(0, 5'b01000, 1, 32'hABC,      0, 32'h0,        0,   5'b01111, 5'b10000, 0, 32'h0,        0, 0); // 26 branch pending
        step(1, 5'b01000, 0, 32'h0,        0, 32'h0,        0,   5'b00000, 5'b00000, 0, 32'h0,        0, 0); // 27 async reset mid-cycle
        step(0, 5'b00000, 0, 32'h0,        0, 32'h0,        0,   5'b00000, 5'b00000, 0, 32'h0,        0, 0); // 28 no redirect after reset
        step(0, 5'b00000, 0, 32'h0,        0, 32'h0,        0,   5'b00000, 5'b00000, 0, 32'h0,        0, 0); // 29
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline stall/flush/redirect controller for the yadan core, generalising the fixed 5-stage stall priority logic to N stages. It resolves per-stage stall requests into a stall vector plus bubble injection, and issues branch and trap redirects with flush masks. Redirects that arrive while an older stage is stalled are held in pending registers instead of being dropped. A stall watchdog flags stuck stalls. It sits beside the pipeline registers and drives their stall/flush inputs and the PC redirect.

Parameters:
STAGES, 5, number of pipeline stages (index 0 = IF, STAGES-1 = WB); legal range 3..8.
ADDR_W, 32, redirect address width.
BRANCH_STAGE, 2, stage that resolves branches (EX); must be >= 1 and < TRAP_STAGE.
TRAP_STAGE, 3, stage that raises traps/interrupts (MEM); must be < STAGES.
TIMEOUT, 1023, consecutive stall cycles before the watchdog fires; minimum 1.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
stall_req_i  in  STAGES  bit i = stage i requests stall
branch_flag_i  in  1  one-cycle branch-taken pulse from BRANCH_STAGE
branch_addr_i  in  ADDR_W  branch target, valid with branch_flag_i
trap_i  in  1  one-cycle trap/interrupt pulse from TRAP_STAGE
trap_addr_i  in  ADDR_W  trap vector, valid with trap_i
timeout_clr_i  in  1  clears the sticky watchdog flag
stall_o  out  STAGES  bit j = hold pipeline register of stage j
flush_o  out  STAGES  bit j = load bubble into stage j
redirect_o  out  1  PC redirect strobe
redirect_addr_o  out  ADDR_W  redirect target
redirect_trap_o  out  1  redirect is a trap (1) or a branch (0)
stall_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset: asynchronous, active-high, on rst. Pending regs and the counter clear, state is RUN, and stall_timeout_o = 0. While rst is high, all outputs are 0.
- Stall resolution: h = highest i with stall_req_i[i] = 1. stall_o[j] = 1 for j <= h. flush_o[h+1] = 1 when h+1 < STAGES (bubble). No request means stall_o = 0 and no bubble.
- Blocking stall: this is a stall with h >= BRANCH_STAGE for branches, and h >= TRAP_STAGE for traps.
- Branch redirect, unblocked branch_flag_i with no trap this cycle: the redirect is combinational in the same cycle.
  - redirect_o = 1, redirect_addr_o = branch_addr_i, redirect_trap_o = 0.
  - flush_o[0..BRANCH_STAGE-1] = 1 and stall_o[0..BRANCH_STAGE-1] is forced to 0; lower-stage stall requests are overridden.
- Trap redirect, unblocked trap_i: same form, using trap_addr_i with redirect_trap_o = 1.
  - Flushes stages 0..TRAP_STAGE and forces their stall bits to 0.
  - Takes priority over a simultaneous branch; that branch is discarded.
- FSM states: RUN, PEND_BR, PEND_TRAP. Transitions are registered on clk.
  - RUN -> PEND_BR: branch_flag_i while blocked. Latch branch_addr_i.
  - RUN or PEND_BR -> PEND_TRAP: trap_i while blocked. Latch trap_addr_i; any pending branch is dropped.
  - PEND_x -> RUN: in the first cycle the blocking condition is gone, the latched redirect issues exactly as an unblocked one (same flush/stall masks) and the state returns to RUN.
  - In PEND_BR, further branch_flag_i pulses are ignored (first wins). A new unblocked trap_i in the release cycle wins over the pending branch.
  - In PEND_TRAP, further trap_i and branch_flag_i are ignored.
- redirect_o is high for exactly one cycle per accepted redirect. When redirect_o = 0, redirect_addr_o = 0.
- Watchdog: counter of ceil(log2(TIMEOUT+1)) bits.
  - Increments each cycle stall_req_i != 0 and clears on any cycle with no request. It saturates at TIMEOUT.
  - The cycle the counter reaches TIMEOUT, stall_timeout_o is set on the next edge and stays set.
  - timeout_clr_i clears the flag and the counter. If set and clear coincide, clear wins.
- Watchdog flag is diagnostic only and does not alter stall_o.
- An asynchronous rst mid-pending discards the pending redirect; no redirect is issued after reset.

Test Plan:
- Default params, stall_req_i = 5'b00100 -> stall_o = 5'b00111, flush_o = 5'b01000, redirect_o = 0.
- stall_req_i = 5'b00010 with branch_flag_i = 1, addr 0x80000040, same cycle -> redirect_o = 1, addr 0x80000040, trap = 0, stall_o = 5'b00000, flush_o = 5'b00011.
- Branch with addr 0x100 while stall_req_i = 5'b01000 held 3 cycles -> no redirect during the stall. The cycle the stall drops: redirect_o = 1, addr 0x100, flush_o[1:0] = 2'b11. A second branch pulse during the stall (addr 0x200) is ignored.
- trap_i (addr 0x80000004) and branch_flag_i (addr 0x300) in the same unblocked cycle -> one redirect, addr 0x80000004, redirect_trap_o = 1, flush_o = 5'b01111. No later branch redirect.
- TIMEOUT = 4, stall_req_i held nonzero -> stall_timeout_o rises after the 4th stall cycle and stays high after the stall ends. timeout_clr_i pulse -> 0.
- Branch is pending in PEND_BR, then rst pulses asynchronously mid-cycle -> outputs are 0 immediately. After release with no stall: redirect_o stays 0 and state is RUN.
